// File: rtl/burst_mem_pkg.sv
// rtl/burst_mem_pkg.sv - shared FSM encoding and burst-type constants for burst_mem
//
// Purpose: state encoding and burst-mode constants used by burst_mem and its
// address generator.
package burst_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  localparam logic BURST_INCR = 1'b0;
  localparam logic BURST_WRAP = 1'b1;

endpackage

// File: rtl/burst_addr_gen.sv
// rtl/burst_addr_gen.sv - combinational next-beat address for INCR/WRAP bursts
//
// Purpose: given the current beat address, the burst start address, the
// length (beats-1) and the burst type, produce the next beat address.
// Ports:
//   cur    in  current beat address
//   start  in  address of the first beat of the burst
//   len    in  beats minus 1
//   wrap   in  BURST_WRAP / BURST_INCR
//   next   out address of the following beat
module burst_addr_gen
  import burst_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int LEN_WIDTH  = 4
) (
  input  logic [ADDR_WIDTH-1:0] cur,
  input  logic [ADDR_WIDTH-1:0] start,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic                  wrap,
  output logic [ADDR_WIDTH-1:0] next
);

  // Work wide enough to hold both an address and the block size len+1.
  localparam int MW = (ADDR_WIDTH > LEN_WIDTH + 1) ? ADDR_WIDTH : LEN_WIDTH + 1;

  logic [MW-1:0] blk;
  logic [MW-1:0] msk;
  logic [MW-1:0] inc;
  logic [MW-1:0] nxt;
  logic          pow2;

  always_comb begin
    blk  = MW'(len) + MW'(1);
    msk  = blk - MW'(1);
    pow2 = (blk & msk) == '0;
    inc  = MW'(cur) + MW'(1);
    // A non power-of-two WRAP block has no natural boundary, so it falls back to INCR.
    if (wrap == BURST_WRAP && pow2) begin
      nxt = (MW'(start) & ~msk) | (inc & msk);
    end else begin
      nxt = inc;
    end
    // Truncation to ADDR_WIDTH gives the silent modulo-DEPTH rollover.
    next = nxt[ADDR_WIDTH-1:0];
  end

endmodule

// File: rtl/burst_mem.sv
// rtl/burst_mem.sv - single-port burst RAM with valid/ready request channel
//
// Purpose: on-chip scratch RAM; each accepted request moves 1..MAX_BURST beats
// with INCR or WRAP addressing, byte-strobed writes and back-pressurable reads.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   valid_i/ready_o                  request handshake
//   wr_rd_i, addr_i, len_i, wrap_i   request fields (direction, start, beats-1, type)
//   wr_valid_i/wr_ready_o            write beat handshake, wr_data_i/wr_strb_i payload
//   wr_done_o                        pulse after the last write beat
//   rd_valid_o/rd_ready_i            read beat handshake, rd_data_o/rd_last_o payload
module burst_mem
  import burst_mem_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int DEPTH        = 16,
  parameter int ADDR_WIDTH   = $clog2(DEPTH),
  parameter int MAX_BURST    = 16,
  parameter int LEN_WIDTH    = $clog2(MAX_BURST),
  parameter bit CLEAR_ON_RST = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic                  wr_rd_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  input  logic                  wrap_i,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  input  logic [WIDTH-1:0]      wr_data_i,
  input  logic [WIDTH/8-1:0]    wr_strb_i,
  output logic                  wr_done_o,
  output logic                  rd_valid_o,
  input  logic                  rd_ready_i,
  output logic [WIDTH-1:0]      rd_data_o,
  output logic                  rd_last_o
);

  logic [WIDTH-1:0] mem [DEPTH];

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] cur;
  logic [ADDR_WIDTH-1:0] start;
  logic [LEN_WIDTH-1:0]  len;
  logic [LEN_WIDTH-1:0]  cnt;
  logic                  wrap;
  logic [ADDR_WIDTH-1:0] nxt_addr;
  logic                  accept;
  logic                  wr_beat;
  logic                  rd_beat;

  // ready_o is only ever high in IDLE, so it alone qualifies acceptance.
  assign accept  = valid_i && ready_o;
  assign wr_beat = wr_valid_i && wr_ready_o;
  assign rd_beat = rd_valid_o && rd_ready_i;

  burst_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .LEN_WIDTH (LEN_WIDTH)
  ) u_addr_gen (
    .cur  (cur),
    .start(start),
    .len  (len),
    .wrap (wrap),
    .next (nxt_addr)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = wr_rd_i ? WRITE : READ;
      WRITE:   if (wr_beat && cnt == len) state_nxt = IDLE;
      READ:    if (rd_beat && rd_last_o) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ready_o    <= 1'b0;
      wr_ready_o <= 1'b0;
      wr_done_o  <= 1'b0;
      rd_valid_o <= 1'b0;
      rd_data_o  <= '0;
      rd_last_o  <= 1'b0;
      cur        <= '0;
      start      <= '0;
      len        <= '0;
      cnt        <= '0;
      wrap       <= 1'b0;
    end else begin
      state      <= state_nxt;
      ready_o    <= (state_nxt == IDLE);
      wr_ready_o <= (state_nxt == WRITE);
      wr_done_o  <= (state == WRITE) && wr_beat && (cnt == len);
      case (state)
        IDLE: begin
          if (accept) begin
            start <= addr_i;
            len   <= len_i;
            wrap  <= wrap_i;
            cur   <= addr_i;
            cnt   <= '0;
            if (!wr_rd_i) begin
              // First read beat is loaded at acceptance for 1-clock latency.
              rd_valid_o <= 1'b1;
              rd_data_o  <= mem[addr_i];
              rd_last_o  <= (len_i == '0);
            end
          end
        end
        WRITE: begin
          if (wr_beat) begin
            cur <= nxt_addr;
            cnt <= cnt + LEN_WIDTH'(1);
          end
        end
        READ: begin
          if (rd_beat) begin
            if (rd_last_o) begin
              rd_valid_o <= 1'b0;
              rd_last_o  <= 1'b0;
            end else begin
              rd_data_o <= mem[nxt_addr];
              rd_last_o <= (cnt + LEN_WIDTH'(1)) == len;
              cur       <= nxt_addr;
              cnt       <= cnt + LEN_WIDTH'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Storage: cleared on reset only when CLEAR_ON_RST; reset always blocks writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (CLEAR_ON_RST) begin
        for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end
    end else if (state == WRITE && wr_beat) begin
      for (int b = 0; b < WIDTH / 8; b++) begin
        if (wr_strb_i[b]) mem[cur][8*b +: 8] <= wr_data_i[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_burst_mem.sv
// tb/tb_burst_mem.sv - directed self-checking bench for burst_mem
//
// Purpose: two instances (memory cleared / kept on reset) share all inputs;
// sel picks which instance's outputs the checks observe.
module tb_burst_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic        wr_rd;
  logic [3:0]  addr;
  logic [3:0]  len;
  logic        wrap;
  logic        wr_valid;
  logic [15:0] wr_data;
  logic [1:0]  wr_strb;
  logic        rd_ready;

  logic        ready0, wr_ready0, wr_done0, rd_valid0, rd_last0;
  logic        ready1, wr_ready1, wr_done1, rd_valid1, rd_last1;
  logic [15:0] rd_data0, rd_data1;

  logic        sel = 1'b0;
  logic        ready, wr_ready, wr_done, rd_valid, rd_last;
  logic [15:0] rd_data;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] wq[$];
  logic [15:0] rq[$];

  always #5 clk = ~clk;

  burst_mem #(.CLEAR_ON_RST(1'b1)) u0 (
    .clk(clk), .rst(rst), .valid_i(valid), .ready_o(ready0), .wr_rd_i(wr_rd),
    .addr_i(addr), .len_i(len), .wrap_i(wrap), .wr_valid_i(wr_valid),
    .wr_ready_o(wr_ready0), .wr_data_i(wr_data), .wr_strb_i(wr_strb),
    .wr_done_o(wr_done0), .rd_valid_o(rd_valid0), .rd_ready_i(rd_ready),
    .rd_data_o(rd_data0), .rd_last_o(rd_last0)
  );

  burst_mem #(.CLEAR_ON_RST(1'b0)) u1 (
    .clk(clk), .rst(rst), .valid_i(valid), .ready_o(ready1), .wr_rd_i(wr_rd),
    .addr_i(addr), .len_i(len), .wrap_i(wrap), .wr_valid_i(wr_valid),
    .wr_ready_o(wr_ready1), .wr_data_i(wr_data), .wr_strb_i(wr_strb),
    .wr_done_o(wr_done1), .rd_valid_o(rd_valid1), .rd_ready_i(rd_ready),
    .rd_data_o(rd_data1), .rd_last_o(rd_last1)
  );

  assign ready    = sel ? ready1    : ready0;
  assign wr_ready = sel ? wr_ready1 : wr_ready0;
  assign wr_done  = sel ? wr_done1  : wr_done0;
  assign rd_valid = sel ? rd_valid1 : rd_valid0;
  assign rd_last  = sel ? rd_last1  : rd_last0;
  assign rd_data  = sel ? rd_data1  : rd_data0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic w_r, input logic [3:0] a, input logic [3:0] l, input logic w);
    int n = 0;
    while (!ready && n < 20) begin
      tick();
      n++;
    end
    vectors++;
    if (ready !== 1'b1) begin
      miscompares++;
      $display("FAIL req_ready: got %b want 1", ready);
    end
    valid = 1'b1; wr_rd = w_r; addr = a; len = l; wrap = w;
    tick();
    valid = 1'b0;
  endtask

  task automatic write_burst(input logic [3:0] a, input logic [3:0] l, input logic w, input logic [1:0] s);
    int pulses = 0;
    req(1'b1, a, l, w);
    for (int i = 0; i <= int'(l); i++) begin
      wr_valid = 1'b1; wr_data = wq[i]; wr_strb = s;
      vectors++;
      if (wr_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL wr_ready beat %0d: got %b want 1", i, wr_ready);
      end
      tick();
      if (wr_done === 1'b1) pulses++;
    end
    wr_valid = 1'b0;
    vectors++;
    if (wr_done !== 1'b1 || ready !== 1'b1) begin
      miscompares++;
      $display("FAIL wr_done_after_last: got done=%b ready=%b want 1 1", wr_done, ready);
    end
    tick();
    if (wr_done === 1'b1) pulses++;
    vectors++;
    if (pulses !== 1) begin
      miscompares++;
      $display("FAIL wr_done_pulses: got %0d want 1", pulses);
    end
  endtask

  task automatic read_burst(input logic [3:0] a, input logic [3:0] l, input logic w,
                            input int stall_at, input int stall_n);
    req(1'b0, a, l, w);
    for (int i = 0; i <= int'(l); i++) begin
      vectors++;
      if (rd_valid !== 1'b1 || rd_data !== rq[i] || rd_last !== (i == int'(l))) begin
        miscompares++;
        $display("FAIL rd_beat %0d @%0h: got v=%b d=%h last=%b want v=1 d=%h last=%b",
                 i, a, rd_valid, rd_data, rd_last, rq[i], (i == int'(l)));
      end
      if (i == stall_at) begin
        rd_ready = 1'b0;
        for (int k = 0; k < stall_n; k++) begin
          tick();
          vectors++;
          if (rd_valid !== 1'b1 || rd_data !== rq[i]) begin
            miscompares++;
            $display("FAIL rd_stall %0d: got v=%b d=%h want v=1 d=%h", k, rd_valid, rd_data, rq[i]);
          end
        end
        rd_ready = 1'b1;
      end
      tick();
    end
    vectors++;
    if (rd_valid !== 1'b0 || ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rd_end: got v=%b ready=%b want 0 1", rd_valid, ready);
    end
  endtask

  task automatic test_reset();
    wq.delete();
    for (int i = 0; i < 16; i++) wq.push_back(16'(16'h1000 + i));
    write_burst(4'd0, 4'd15, 1'b0, 2'b11);
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      vectors++;
      if ({ready, wr_ready, wr_done, rd_valid, rd_last, rd_data} !== 21'd0) begin
        miscompares++;
        $display("FAIL reset_outputs: got r=%b wr=%b d=%b v=%b l=%b data=%h want all 0",
                 ready, wr_ready, wr_done, rd_valid, rd_last, rd_data);
      end
    end
    rst = 1'b0;
    tick();
    rq.delete();
    for (int i = 0; i < 16; i++) rq.push_back(16'h0000);
    read_burst(4'd0, 4'd15, 1'b0, -1, 0);
  endtask

  task automatic test_incr();
    wq = '{16'hA000, 16'hA001, 16'hA002, 16'hA003};
    write_burst(4'd4, 4'd3, 1'b0, 2'b11);
    rq = '{16'hA000, 16'hA001, 16'hA002, 16'hA003};
    read_burst(4'd4, 4'd3, 1'b0, -1, 0);
  endtask

  task automatic test_strobe();
    wq = '{16'hFFFF};
    write_burst(4'd2, 4'd0, 1'b0, 2'b11);
    wq = '{16'h1234};
    write_burst(4'd2, 4'd0, 1'b0, 2'b01);
    rq = '{16'hFF34};
    read_burst(4'd2, 4'd0, 1'b0, -1, 0);
  endtask

  task automatic test_wrap();
    // WRAP start 6 len 3 lands on 6,7,4,5.
    wq = '{16'hB000, 16'hB001, 16'hB002, 16'hB003};
    write_burst(4'd6, 4'd3, 1'b1, 2'b11);
    rq = '{16'hB002, 16'hB003, 16'hB000, 16'hB001};
    read_burst(4'd4, 4'd3, 1'b0, -1, 0);
    // INCR start 14 len 3 rolls over: 14,15,0,1.
    wq = '{16'hC000, 16'hC001, 16'hC002, 16'hC003};
    write_burst(4'd14, 4'd3, 1'b0, 2'b11);
    rq = '{16'hC002, 16'hC003};
    read_burst(4'd0, 4'd1, 1'b0, -1, 0);
    rq = '{16'hC000, 16'hC001, 16'hC002, 16'hC003};
    read_burst(4'd14, 4'd3, 1'b0, -1, 0);
    // WRAP with 3 beats is not a power of two: behaves as INCR 9,10,11.
    wq = '{16'hF000, 16'hF001, 16'hF002};
    write_burst(4'd9, 4'd2, 1'b1, 2'b11);
    rq = '{16'hF000, 16'hF001, 16'hF002};
    read_burst(4'd9, 4'd2, 1'b0, -1, 0);
  endtask

  task automatic test_read_stall();
    wq = '{16'h5A00, 16'h5A01, 16'h5A02, 16'h5A03};
    write_burst(4'd8, 4'd3, 1'b0, 2'b11);
    rq = '{16'h5A00, 16'h5A01, 16'h5A02, 16'h5A03};
    read_burst(4'd8, 4'd3, 1'b0, 1, 3);
  endtask

  task automatic test_reset_mid_burst();
    sel = 1'b1;
    wq = '{16'hD000, 16'hD001, 16'hD002, 16'hD003};
    write_burst(4'd0, 4'd3, 1'b0, 2'b11);
    req(1'b1, 4'd0, 4'd3, 1'b0);
    wr_valid = 1'b1; wr_strb = 2'b11;
    wr_data = 16'hE000; tick();
    wr_data = 16'hE001; tick();
    wr_data = 16'hE002; rst = 1'b1; tick();
    vectors++;
    if (wr_done !== 1'b0 || ready !== 1'b0 || wr_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_burst: got done=%b ready=%b wr_ready=%b want 0 0 0", wr_done, ready, wr_ready);
    end
    rst = 1'b0; wr_valid = 1'b0;
    tick();
    vectors++;
    if (ready !== 1'b1 || wr_done !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_idle: got ready=%b done=%b want 1 0", ready, wr_done);
    end
    rq = '{16'hE000, 16'hE001, 16'hD002, 16'hD003};
    read_burst(4'd0, 4'd3, 1'b0, -1, 0);
    sel = 1'b0;
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; wr_rd = 1'b0; addr = '0; len = '0; wrap = 1'b0;
    wr_valid = 1'b0; wr_data = '0; wr_strb = '0; rd_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    test_reset();
    test_incr();
    test_strobe();
    test_wrap();
    test_read_stall();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
